// File: rtl/cto_pkg.sv
// Shared types and constants for the truth-table scanner and its settle timer.
package cto_pkg;

    localparam int unsigned NUM_VEC  = 16;
    localparam int unsigned VEC_W    = 4;
    localparam int unsigned ERR_W    = 5;
    localparam int unsigned SETTLE_W = 4;

    localparam logic [NUM_VEC-1:0] CTO3_S1_EXPECTED = 16'h3801;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } scan_state_t;

    // Captured result of one scan; cleared together on an accepted start.
    typedef struct packed {
        logic [NUM_VEC-1:0] tt;
        logic [ERR_W-1:0]   err;
        logic               pass;
    } scan_result_t;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter with a registered zero flag; paces each vector's hold time.
module settle_timer
    import cto_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_i,
    input  logic [SETTLE_W-1:0] load_val_i,
    output logic                zero_o
);

    logic [SETTLE_W-1:0] cnt_q;
    logic [SETTLE_W-1:0] cnt_d;

    // Load wins over counting; the counter parks at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - SETTLE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            zero_o <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            zero_o <= (cnt_d == '0);
        end
    end

endmodule

// File: rtl/truth_table_scanner.sv
// Drives all 16 input vectors into a 4-input circuit, captures s1 per vector,
// and grades the captured truth table against a golden constant.
module truth_table_scanner
    import cto_pkg::*;
#(
    parameter int unsigned        SETTLE_CYCLES = 1,
    parameter logic [NUM_VEC-1:0] EXPECTED      = CTO3_S1_EXPECTED
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               s1,
    output logic               a,
    output logic               b,
    output logic               c,
    output logic               d,
    output logic               busy,
    output logic               done,
    output logic [NUM_VEC-1:0] table_o,
    output logic [ERR_W-1:0]   err_cnt,
    output logic               pass
);

    // With no settle time the DRIVE state is bypassed entirely.
    localparam logic                SKIP_DRIVE = (SETTLE_CYCLES == 0);
    localparam int unsigned         LOAD_INT   = (SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1;
    localparam logic [SETTLE_W-1:0] LOAD_VAL   = SETTLE_W'(LOAD_INT);
    localparam logic [VEC_W-1:0]    LAST_VEC   = VEC_W'(NUM_VEC - 1);

    scan_state_t        state_q;
    logic [VEC_W-1:0]   idx_q;
    logic               busy_q;
    logic               done_q;
    scan_result_t       res_q;
    logic [ERR_W-1:0]   err_d;
    logic               timer_load;
    logic               timer_zero;
    scan_state_t        drive_entry;

    assign drive_entry = SKIP_DRIVE ? SAMPLE : DRIVE;

    // Timer is (re)loaded on every transition into the hold phase of a vector.
    assign timer_load = ((state_q == IDLE) && start) ||
                        ((state_q == SAMPLE) && (idx_q != LAST_VEC));

    always_comb begin
        err_d = res_q.err;
        if (s1 != EXPECTED[idx_q]) begin
            err_d = res_q.err + ERR_W'(1);
        end
    end

    settle_timer u_settle_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (timer_load),
        .load_val_i (LOAD_VAL),
        .zero_o     (timer_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= drive_entry;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        res_q   <= '0;
                    end
                end
                DRIVE: begin
                    if (timer_zero) begin
                        state_q <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    res_q.tt[idx_q] <= s1;
                    res_q.err       <= err_d;
                    // pass is settled on entry to DONE so it is valid alongside done.
                    if (idx_q == LAST_VEC) begin
                        state_q    <= DONE;
                        done_q     <= 1'b1;
                        res_q.pass <= (err_d == '0);
                    end else begin
                        state_q <= drive_entry;
                        idx_q   <= idx_q + VEC_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign {a, b, c, d} = idx_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign table_o      = res_q.tt;
    assign err_cnt      = res_q.err;
    assign pass         = res_q.pass;

endmodule

// File: doc/truth_table_scanner.md
# truth_table_scanner

Sequential stimulus/response engine for the 4-input, 2-output combinational gate-level circuits in this project. On a start pulse it drives all 16 input vectors `{a,b,c,d}` into the circuit under test, waits a fixed settle time per vector, and captures the returned `s1` bit into a 16-bit truth table. It then compares that table against an expected constant and reports pass/fail plus a mismatch count. It sits beside the combinational block as its driving and sampling end, for on-chip self-test and bench reuse.

## Interface
- `SETTLE_CYCLES`, default 1: cycles each vector is held before `s1` is sampled; legal range 0..15.
- `EXPECTED`, default 16'h3801: golden `s1` truth table; bit i corresponds to vector i, with `a` as the MSB.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; honoured only in IDLE.
- `s1`  in  1  response from the circuit under test.
- `a`, `b`, `c`, `d`  out  1 each  stimulus bits, registered; `{a,b,c,d}` equals the current vector index.
- `busy`  out  1  high from the cycle after an accepted start through the DONE cycle.
- `done`  out  1  one-cycle pulse in the DONE state.
- `table_o`  out  16  captured truth table; held until the next accepted start.
- `err_cnt`  out  5  popcount of `table_o ^ EXPECTED` (0..16); held like `table_o`.
- `pass`  out  1  `err_cnt == 0`; valid when `done` is high and held afterwards.

## Operation
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE: outputs hold. If `start`=1, then next state is DRIVE, vector index = 0, and `table_o`, `err_cnt`, `pass` clear to 0.
- DRIVE: `{a,b,c,d}` = index. The settle counter counts `SETTLE_CYCLES` cycles, then the FSM moves to SAMPLE. With `SETTLE_CYCLES`=0, DRIVE lasts 0 cycles and the FSM goes straight to SAMPLE.
- SAMPLE (one cycle): `table_o[index] <= s1`, and `err_cnt` increments if `s1 != EXPECTED[index]`.
  - If index == 15: next state is DONE.
  - Otherwise: index increments and the FSM returns to DRIVE.
- DONE (one cycle): `done`=1 and `pass` updates. Next state is IDLE.
- `start` in DRIVE, SAMPLE or DONE is ignored and is not queued.
- The vector index is a 4-bit register. It never wraps during a scan; after DONE it holds at 15 until the next start.
- Reset (at any time, including mid-scan) forces:
  - state = IDLE
  - `{a,b,c,d}` = 0
  - `busy`, `done`, `pass` = 0
  - `table_o` = 0, `err_cnt` = 0
  
  A scan interrupted by reset is discarded and is not resumed.

## Timing
- Call the edge at which `start` is sampled in IDLE t0.
  - Vector 0 appears on `a..d` and `busy` goes high after t0.
- Each vector occupies `SETTLE_CYCLES`+1 cycles. `s1` is sampled at the closing edge of its SAMPLE cycle, so it has `SETTLE_CYCLES`+1 cycles to settle.
- `done` is high in cycle number 16·(`SETTLE_CYCLES`+1)+1 after t0. That is cycle 33 for the default.
- `busy` falls together with `done` as the FSM returns to IDLE.
- A start asserted in the cycle `done` is high is ignored. The earliest accepted restart is the following cycle.
- All outputs are registered; there is no combinational path from `s1` or `start` to any output.

## Structure
- Package `cto_pkg` holds:
  - the state enum `scan_state_t`
  - `NUM_VEC` = 16
  - `VEC_W` = 4
  - `CTO3_S1_EXPECTED` = 16'h3801, used as the default for `EXPECTED`
- One sub-module, `settle_timer`: a loadable down-counter with a zero flag. It is loaded on entry to DRIVE and drives the DRIVE→SAMPLE transition.

## Test plan
- Reset values: assert `rst_n`=0 with random stimulus → every output is 0. Release reset → outputs stay 0 while `start`=0.
- Golden circuit, `SETTLE_CYCLES`=1: pulse `start` → `done` at cycle 33, `table_o`=16'h3801, `err_cnt`=0, `pass`=1. `a..d` steps 0..15, each value held 2 cycles.
- Stuck-at-0 `s1` → `table_o`=16'h0000, `err_cnt`=4, `pass`=0. Stuck-at-1 `s1` → `table_o`=16'hFFFF, `err_cnt`=12.
- Assert `start` on every cycle during a scan → exactly one `done` pulse and unchanged timing. A further start in the `done` cycle is ignored; a start in the next cycle begins a new scan.
- Drive `rst_n` low at cycle 10 of a scan → all outputs are 0 immediately (asynchronously). After release, a fresh start produces a full correct scan.
- `SETTLE_CYCLES`=0 → `done` at cycle 17 with `table_o`=16'h3801. `SETTLE_CYCLES`=15 → `done` at cycle 257.
